// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: one-word holding register feeding a shift register,
// framed as start / 8 data LSB-first / optional parity / 1-2 stop bits.
module uart_tx #(
  parameter int UART_BPS  = 9600,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       pi_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic          ready_q, ready_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end, load;

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    par_d        = par_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load         = 1'b0;
    bit_end      = (cnt_q == CNT_LAST);
    cnt_d        = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;

    // tx is registered, so each branch drives the level of the bit being entered
    case (state_q)
      S_IDLE: if (hold_valid_q) load = 1'b1;
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      S_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          if (PARITY != 0) begin
            state_d = S_PAR;
            tx_d    = (PARITY == 2) ? par_q : ~par_q;
          end else begin
            state_d = S_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_PAR: if (bit_end) begin
        state_d = S_STOP;
        stop_d  = 1'b0;
        tx_d    = 1'b1;
      end
      S_STOP: if (bit_end) begin
        if (STOP_BITS == 2 && !stop_q) begin
          stop_d = 1'b1;
        end else begin
          done_d = 1'b1;
          if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d      = hold_q;
      par_d        = ^hold_q;
      state_d      = S_START;
      tx_d         = 1'b0;
      busy_d       = 1'b1;
      hold_valid_d = 1'b0;
    end

    // ready_q is low whenever a load can happen, so this never collides with it
    if (pi_flag && ready_q) begin
      hold_valid_d = 1'b1;
      hold_d       = pi_data;
    end

    ready_d = !hold_valid_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ready_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pi_ready = ready_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; four instances cover
// no parity, even, odd, and two stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data [4];
  logic       flag [4];
  logic       rdy  [4];
  logic       txo  [4];
  logic       busy [4];
  logic       done [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .sys_rst(rst), .pi_data(data[0]), .pi_flag(flag[0]),
    .pi_ready(rdy[0]), .tx(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY(2), .STOP_BITS(1)) u1 (
    .sys_clk(clk), .sys_rst(rst), .pi_data(data[1]), .pi_flag(flag[1]),
    .pi_ready(rdy[1]), .tx(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY(1), .STOP_BITS(1)) u2 (
    .sys_clk(clk), .sys_rst(rst), .pi_data(data[2]), .pi_flag(flag[2]),
    .pi_ready(rdy[2]), .tx(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY(0), .STOP_BITS(2)) u3 (
    .sys_clk(clk), .sys_rst(rst), .pi_data(data[3]), .pi_flag(flag[3]),
    .pi_ready(rdy[3]), .tx(txo[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  // Outputs settle 1 time unit after the rising edge; inputs are driven there too.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line level of frame bit idx for a no-parity frame (start, 8 data, stops).
  function automatic logic fbit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin flag[k] = 1'b0; data[k] = 8'h00; end
    step(3);
    for (int k = 0; k < 4; k++) begin
      checks++; if (txo[k] !== 1'b1) begin errors++; $display("FAIL reset_tx[%0d]: got %b exp 1", k, txo[k]); end
      checks++; if (rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b exp 0", k, rdy[k]); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b exp 0", k, busy[k]); end
      checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b exp 0", k, done[k]); end
    end
    rst = 1'b0;
    step(1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rdy[k] !== 1'b1) begin errors++; $display("FAIL release_ready[%0d]: got %b exp 1", k, rdy[k]); end
      checks++; if (txo[k] !== 1'b1) begin errors++; $display("FAIL release_tx[%0d]: got %b exp 1", k, txo[k]); end
    end
  endtask

  task automatic test_basic;
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;  // 0xA5 frame, bit 0 = start
    data[0] = 8'hA5; flag[0] = 1'b1;
    step(1);
    flag[0] = 1'b0;
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL basic_ready_after_hs: got %b exp 0", rdy[0]); end
    checks++; if (txo[0] !== 1'b1) begin errors++; $display("FAIL basic_tx_before_fall: got %b exp 1", txo[0]); end
    step(1);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_after_load: got %b exp 1", rdy[0]); end
    for (int t = 0; t < 100; t++) begin
      checks++; if (txo[0] !== exp_bits[t/10]) begin errors++; $display("FAIL basic_tx t=%0d: got %b exp %b", t, txo[0], exp_bits[t/10]); end
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy t=%0d: got %b exp 1", t, busy[0]); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL basic_done_early t=%0d: got %b exp 0", t, done[0]); end
      step(1);
    end
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL basic_done: got %b exp 1", done[0]); end
    checks++; if (txo[0] !== 1'b1) begin errors++; $display("FAIL basic_idle_tx: got %b exp 1", txo[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b exp 0", busy[0]); end
    step(1);
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b exp 0", done[0]); end
  endtask

  task automatic test_parity;
    int         inst [4] = '{1, 2, 1, 2};
    logic [7:0] dv   [4] = '{8'hA5, 8'hA5, 8'h01, 8'h01};
    logic       pb   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       e;
    for (int v = 0; v < 4; v++) begin
      automatic int k = inst[v];
      data[k] = dv[v]; flag[k] = 1'b1;
      step(1);
      flag[k] = 1'b0;
      step(1);
      for (int t = 0; t < 110; t++) begin
        e = (t / 10 == 9) ? pb[v] : fbit(dv[v], t / 10);
        checks++; if (txo[k] !== e) begin errors++; $display("FAIL parity_tx v=%0d t=%0d: got %b exp %b", v, t, txo[k], e); end
        step(1);
      end
      checks++; if (done[k] !== 1'b1) begin errors++; $display("FAIL parity_done v=%0d: got %b exp 1", v, done[k]); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL parity_busy_end v=%0d: got %b exp 0", v, busy[k]); end
      step(2);
    end
  endtask

  task automatic test_back_to_back;
    logic e;
    int   ndone = 0;
    data[3] = 8'h00; flag[3] = 1'b1;
    step(1);
    checks++; if (rdy[3] !== 1'b0) begin errors++; $display("FAIL b2b_ready_hs1: got %b exp 0", rdy[3]); end
    data[3] = 8'hFF;
    step(1);
    checks++; if (txo[3] !== 1'b0) begin errors++; $display("FAIL b2b_first_start: got %b exp 0", txo[3]); end
    step(1);
    flag[3] = 1'b0;
    for (int t = 1; t <= 220; t++) begin
      if (t < 110)      e = fbit(8'h00, t / 10);
      else if (t < 220) e = fbit(8'hFF, (t - 110) / 10);
      else              e = 1'b1;
      checks++; if (txo[3] !== e) begin errors++; $display("FAIL b2b_tx t=%0d: got %b exp %b", t, txo[3], e); end
      checks++; if (busy[3] !== (t < 220)) begin errors++; $display("FAIL b2b_busy t=%0d: got %b exp %b", t, busy[3], t < 220); end
      checks++; if (rdy[3] !== (t >= 110)) begin errors++; $display("FAIL b2b_ready t=%0d: got %b exp %b", t, rdy[3], t >= 110); end
      checks++; if (done[3] !== (t == 110 || t == 220)) begin errors++; $display("FAIL b2b_done t=%0d: got %b", t, done[3]); end
      if (done[3] === 1'b1) ndone++;
      step(1);
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", ndone); end
  endtask

  task automatic test_ignore;
    logic e;
    data[0] = 8'h5A; flag[0] = 1'b1;
    step(1);
    flag[0] = 1'b0;
    step(1);
    checks++; if (txo[0] !== 1'b0) begin errors++; $display("FAIL ign_start: got %b exp 0", txo[0]); end
    data[0] = 8'hC3; flag[0] = 1'b1;
    step(1);
    for (int t = 1; t < 230; t++) begin
      if (t < 100)      e = fbit(8'h5A, t / 10);
      else if (t < 200) e = fbit(8'hC3, (t - 100) / 10);
      else              e = 1'b1;
      checks++; if (txo[0] !== e) begin errors++; $display("FAIL ign_tx t=%0d: got %b exp %b", t, txo[0], e); end
      checks++; if (rdy[0] !== (t >= 100)) begin errors++; $display("FAIL ign_ready t=%0d: got %b exp %b", t, rdy[0], t >= 100); end
      checks++; if (done[0] !== (t == 100 || t == 200)) begin errors++; $display("FAIL ign_done t=%0d: got %b", t, done[0]); end
      checks++; if (busy[0] !== (t < 200)) begin errors++; $display("FAIL ign_busy t=%0d: got %b exp %b", t, busy[0], t < 200); end
      flag[0] = (t < 100) ? t[0] : 1'b0;
      data[0] = 8'(t * 37);
      step(1);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] exp_bits;
    exp_bits = 11'b10001111000;  // 0x3C with even parity 0, bit 0 = start
    data[1] = 8'h96; flag[1] = 1'b1;
    step(1);
    data[1] = 8'h0F;
    step(2);
    flag[1] = 1'b0;
    step(34);
    rst = 1'b1;
    step(1);
    checks++; if (txo[1] !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b exp 1", txo[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b exp 0", busy[1]); end
    checks++; if (done[1] !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b exp 0", done[1]); end
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b exp 0", rdy[1]); end
    rst = 1'b0;
    step(1);
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL rmid_release_ready: got %b exp 1", rdy[1]); end
    for (int t = 0; t < 150; t++) begin
      checks++; if (txo[1] !== 1'b1 || busy[1] !== 1'b0) begin
        errors++; $display("FAIL rmid_no_stale_frame t=%0d: got tx=%b busy=%b exp tx=1 busy=0", t, txo[1], busy[1]);
      end
      step(1);
    end
    data[1] = 8'h3C; flag[1] = 1'b1;
    step(1);
    flag[1] = 1'b0;
    step(1);
    for (int t = 0; t < 110; t++) begin
      checks++; if (txo[1] !== exp_bits[t/10]) begin errors++; $display("FAIL rmid_3c_tx t=%0d: got %b exp %b", t, txo[1], exp_bits[t/10]); end
      step(1);
    end
    checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL rmid_3c_done: got %b exp 1", done[1]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, the transmit counterpart to the design's UART receiver. It accepts 8-bit words over a valid/ready handshake and buffers one word while another is on the line. It serialises each word LSB-first as start, 8 data bits, optional parity and 1 or 2 stop bits on `tx`, at `CLK_FREQ/UART_BPS` clocks per bit. Consecutive frames go out back-to-back with no idle gap when the buffer is kept full.

## Interface
- `UART_BPS`, 9600: line baud rate.
- `CLK_FREQ`, 50_000_000: `sys_clk` frequency in Hz.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even; other values are illegal.
- `STOP_BITS`, 1: 1 or 2; other values are illegal.

- `sys_clk`  in  1  single system clock; all logic is on the rising edge.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `pi_data`  in  8  word to send; sampled on handshake.
- `pi_flag`  in  1  word valid.
- `pi_ready`  out  1  holding register empty; handshake completes when `pi_flag && pi_ready` at a rising edge.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high while a frame is on the line (start bit through last stop bit).
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Bit period: `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` (integer division), which must be ≥ 2.
- Baud counter: width `$clog2(BAUD_CNT_MAX)`. It counts 0..`BAUD_CNT_MAX-1`, wraps to 0 at the end of each bit, and is held at 0 in IDLE.
- Holding register: 8 data bits plus `hold_valid`.
  - Handshake sets `hold_valid` and captures `pi_data`.
  - Moving the word into the shifter clears `hold_valid`.
  - `pi_ready` is registered and equals the next-state value of `!hold_valid`.
  - While `pi_ready` is low, `pi_flag` and `pi_data` are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If `hold_valid` is set, load the shifter and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: `tx`=shifter[0]; shift right once per bit; bit index runs 0..7. After bit 7, go to PARITY if `PARITY`≠0, else STOP.
  - PARITY: `tx` = XOR of the 8 data bits for even parity, its inverse for odd; one bit period, then STOP.
  - STOP: `tx`=1 for `STOP_BITS` bit periods. At the end:
    - pulse `tx_done`;
    - if `hold_valid` is set, load the shifter and go directly to START, so the start bit begins on that same edge;
    - otherwise go to IDLE.
- The data word is latched at shifter load; later `pi_data` changes never affect the frame in flight.
- A handshake is allowed during any state, including the STOP end-edge. If the handshake and the shifter load occur on the same edge (buffer full), the load happens and `pi_ready` is low that cycle, so no handshake can coincide with it.

## Timing
- Reset values: `tx`=1, `pi_ready`=0, `tx_busy`=0, `tx_done`=0, FSM=IDLE, `hold_valid`=0, counters=0.
- `pi_ready` goes to 1 at the first edge after `sys_rst` deasserts.
- Reset mid-frame aborts the frame immediately: `tx` is 1 from the reset edge and the buffered word is discarded.
- Latency, idle case:
  - handshake at edge N → `hold_valid` set at N;
  - shifter loaded and `tx` falls at edge N+1;
  - `tx_busy` rises at N+1;
  - `pi_ready` is 0 after N and returns to 1 after N+1.
- Frame length: `BAUD_CNT_MAX × (10 + (PARITY≠0) + (STOP_BITS−1))` cycles. Every bit is exactly `BAUD_CNT_MAX` cycles with no jitter.
- `tx_done` is high for exactly the one cycle following the final stop-bit edge.
- `tx_busy` falls on the edge that enters IDLE; it stays high across back-to-back frames.

## Test plan
- Setup for every scenario: `CLK_FREQ`=50_000_000, `UART_BPS`=5_000_000, giving `BAUD_CNT_MAX`=10.
- `PARITY`=0, `STOP_BITS`=1, send 0xA5 → `tx` per 10-cycle bit: 0,1,0,1,0,0,1,0,1,1. `tx` falls 1 cycle after the handshake; `tx_done` pulses 100 cycles after the fall; then IDLE with `tx`=1.
- `PARITY`=2, then `PARITY`=1, each sending 0xA5 → parity bit 0 (even), 1 (odd); frame is 110 cycles. For 0x01, parity is 1 (even) and 0 (odd).
- `STOP_BITS`=2, `pi_flag` held high with 0x00 then 0xFF → second start bit begins exactly 110 cycles after the first. No idle cycle between frames; `tx_busy` stays high throughout; `pi_ready` is low while the buffer is full; two `tx_done` pulses.
- Change `pi_data` and toggle `pi_flag` while `pi_ready`=0, and change `pi_data` after the shifter load → transmitted bits are unchanged and no extra frame is produced.
- Assert `sys_rst` for 1 cycle mid-DATA with a second word buffered → `tx`=1 from that edge and all outputs at reset values. The buffered word is never sent; a new 0x3C after release transmits correctly.
